// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_pkg
//  Purpose  : Shared types and constants for the hazard/exception controller:
//             store-sequencer state encoding, MIPS exception codes, default
//             exception vector and a low-bit mask helper.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package hazard_pkg;

  // Store sequencer states
  typedef enum logic [1:0] {
    SEQ_IDLE   = 2'd0,
    SEQ_WAIT   = 2'd1,
    SEQ_COMMIT = 2'd2
  } seq_state_e;

  // Wait counter width; covers STORE_WAIT up to 15
  localparam int unsigned SEQ_CNT_W = 4;

  // Exception codes presented on excepttype
  localparam logic [31:0] EXC_INT     = 32'h0000_0001;
  localparam logic [31:0] EXC_SYS     = 32'h0000_0008;
  localparam logic [31:0] EXC_INV     = 32'h0000_000a;
  localparam logic [31:0] EXC_OVF     = 32'h0000_000c;
  localparam logic [31:0] EXC_TRAP    = 32'h0000_000d;
  localparam logic [31:0] EXC_ERET    = 32'h0000_000e;
  localparam logic [31:0] EXC_TLBMISS = 32'h0000_000f;

  localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'h8000_12a0;

  // Mask with bits 0..idx set; a negative idx yields an empty mask.
  function automatic logic [31:0] low_mask(input int idx);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 32; i++) begin
      if (i <= idx) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_ctrl_if
//  Purpose  : Bundles the pipeline-side request/response signals of
//             hazard_ctrl. master = pipeline driving requests,
//             slave = hazard_ctrl producing stall/flush/redirect/strobe.
//  Signals  : stallreq_i, mem_we_i, excepttype_i, cp0_epc_i   (requests)
//             stall_o, flush_o, new_pc_o, mem_we_o, store_busy_o (responses)
//             stall_cycles_o, flush_count_o  (only with HAZARD_PERF_CNT_EN)
//  Revision : 1.0 - initial release
// ============================================================================
interface hazard_ctrl_if #(
  parameter int NSTAGE = 6
);
  logic [NSTAGE-1:0] stallreq_i;
  logic              mem_we_i;
  logic [31:0]       excepttype_i;
  logic [31:0]       cp0_epc_i;

  logic [NSTAGE-1:0] stall_o;
  logic              flush_o;
  logic [31:0]       new_pc_o;
  logic              mem_we_o;
  logic              store_busy_o;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0]       stall_cycles_o;
  logic [31:0]       flush_count_o;
`endif

  modport master (
`ifdef HAZARD_PERF_CNT_EN
    input  stall_cycles_o, flush_count_o,
`endif
    output stallreq_i, mem_we_i, excepttype_i, cp0_epc_i,
    input  stall_o, flush_o, new_pc_o, mem_we_o, store_busy_o
  );

  modport slave (
`ifdef HAZARD_PERF_CNT_EN
    output stall_cycles_o, flush_count_o,
`endif
    input  stallreq_i, mem_we_i, excepttype_i, cp0_epc_i,
    output stall_o, flush_o, new_pc_o, mem_we_o, store_busy_o
  );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl_store_seq.sv
`default_nettype none
// ============================================================================
//  Module   : store_seq
//  Purpose  : Multi-cycle MEM-stage store sequencer. A store holds the pipe
//             for STORE_WAIT cycles, then issues one write strobe cycle.
//  Ports    : clk, rst    - clock, synchronous active-high reset
//             mem_we_i    - MEM-stage instruction is a store
//             abort       - exception: drop any store in flight
//             hold        - upstream stall: freeze state and counter
//             active      - store waiting (hold stages 0..MEM)
//             commit      - strobe cycle (MEM advances)
//             busy        - sequencer not IDLE
//  Revision : 1.0 - initial release
// ============================================================================
module store_seq
  import hazard_pkg::*;
#(
  parameter int unsigned STORE_WAIT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic mem_we_i,
  input  logic abort,
  input  logic hold,
  output logic active,
  output logic commit,
  output logic busy
);

  localparam logic [SEQ_CNT_W-1:0] CNT_LOAD = SEQ_CNT_W'(STORE_WAIT - 1);
  localparam logic [SEQ_CNT_W-1:0] CNT_ONE  = SEQ_CNT_W'(1);

  seq_state_e            state_q, state_d;
  logic [SEQ_CNT_W-1:0]  cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SEQ_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    active  = 1'b0;
    commit  = 1'b0;

    case (state_q)
      SEQ_IDLE: begin
        if (mem_we_i) begin
          active  = 1'b1;
          cnt_d   = CNT_LOAD;
          state_d = (STORE_WAIT == 1) ? SEQ_COMMIT : SEQ_WAIT;
        end
      end
      SEQ_WAIT: begin
        if (mem_we_i) begin
          active = 1'b1;
          cnt_d  = cnt_q - 1'b1;
          // Counter reaching zero this cycle means the strobe comes next
          if (cnt_q <= CNT_ONE) state_d = SEQ_COMMIT;
        end else begin
          // Store vanished (flushed upstream): give up without a strobe
          state_d = SEQ_IDLE;
          cnt_d   = '0;
        end
      end
      SEQ_COMMIT: begin
        commit  = mem_we_i;
        state_d = SEQ_IDLE;
      end
      default: begin
        state_d = SEQ_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Abort outranks hold: an exception always kills the store
    if (abort) begin
      state_d = SEQ_IDLE;
      cnt_d   = '0;
    end else if (hold) begin
      state_d = state_q;
      cnt_d   = cnt_q;
    end
  end

  assign busy = (state_q != SEQ_IDLE);

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_ctrl
//  Purpose  : Pipeline hazard/exception controller. Priority: exception
//             flush/redirect > stage stall requests > store sequencer.
//  Ports    : clk   - core clock
//             rst   - synchronous active-high reset (forces outputs to 0)
//             bus   - hazard_ctrl_if.slave (requests in, stall/flush/
//                     new_pc/mem_we/store_busy out)
//  Options  : HAZARD_PERF_CNT_EN adds saturating stall_cycles_o and
//             flush_count_o counters on the interface.
//  Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int          NSTAGE     = 6,
  parameter int          MEM_STAGE  = 4,
  parameter int unsigned STORE_WAIT = 1,
  parameter logic [31:0] EXC_VECTOR = DEFAULT_EXC_VECTOR,
  parameter logic [31:0] ERET_CODE  = EXC_ERET
) (
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.slave  bus
);

  // Store hold masks: waiting freezes MEM and above-side stages, the strobe
  // cycle releases MEM so the store retires.
  localparam logic [NSTAGE-1:0] MEM_HOLD    = NSTAGE'(low_mask(MEM_STAGE));
  localparam logic [NSTAGE-1:0] COMMIT_HOLD = NSTAGE'(low_mask(MEM_STAGE - 1));

  logic [NSTAGE-1:0] req_mask;
  logic              exc_hit;
  logic              any_req;
  logic              seq_active;
  logic              seq_commit;
  logic              seq_busy;

  logic [NSTAGE-1:0] stall;
  logic              flush;
  logic [31:0]       new_pc;
  logic              mem_we;

  assign exc_hit = (bus.excepttype_i != 32'h0);
  assign any_req = |bus.stallreq_i;

  // A stall at stage k holds every earlier stage too: bit k of the mask is
  // set when any request at index >= k is present. The last stage is never
  // held.
  for (genvar k = 0; k < NSTAGE - 1; k++) begin : g_req_mask
    assign req_mask[k] = |bus.stallreq_i[NSTAGE-1:k];
  end
  assign req_mask[NSTAGE-1] = 1'b0;

  store_seq #(
    .STORE_WAIT (STORE_WAIT)
  ) u_store_seq (
    .clk      (clk),
    .rst      (rst),
    .mem_we_i (bus.mem_we_i),
    .abort    (exc_hit),
    .hold     (any_req),
    .active   (seq_active),
    .commit   (seq_commit),
    .busy     (seq_busy)
  );

  always_comb begin
    stall  = '0;
    flush  = 1'b0;
    new_pc = '0;
    mem_we = 1'b0;
    if (!rst) begin
      if (exc_hit) begin
        flush  = 1'b1;
        new_pc = (bus.excepttype_i == ERET_CODE) ? bus.cp0_epc_i : EXC_VECTOR;
      end else if (any_req) begin
        stall = req_mask;
      end else if (seq_active) begin
        stall = MEM_HOLD;
      end else if (seq_commit) begin
        stall  = COMMIT_HOLD;
        mem_we = 1'b1;
      end
    end
  end

  assign bus.stall_o      = stall;
  assign bus.flush_o      = flush;
  assign bus.new_pc_o     = new_pc;
  assign bus.mem_we_o     = mem_we;
  assign bus.store_busy_o = seq_busy & ~rst;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_count_q,  flush_count_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  // Both counters stick at all-ones instead of wrapping
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (stall[0] && (stall_cycles_q != 32'hffff_ffff)) stall_cycles_d = stall_cycles_q + 32'd1;
    if (flush && (flush_count_q != 32'hffff_ffff))     flush_count_d  = flush_count_q + 32'd1;
  end

  assign bus.stall_cycles_o = rst ? 32'h0 : stall_cycles_q;
  assign bus.flush_count_o  = rst ? 32'h0 : flush_count_q;
`endif

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Parametrised pipeline hazard/exception controller for the in-order MIPS core; next generation of the stall/flush control unit.
- Turns per-stage stall requests, MEM-stage store sequencing and exception codes into stall mask, flush, redirect PC and gated memory write-enable.
- Replaces the single-bit store toggle with a counted multi-cycle store sequencer (configurable SRAM write wait).
- Generalised over stage count and exception vector.

Parameters:
- NSTAGE, 6, number of pipeline stage enables in the stall vector (bit 0 = PC/IF side).
- MEM_STAGE, 4, index of the MEM stage; its stall request and store sequencing are anchored here.
- STORE_WAIT, 1, idle cycles before the write strobe; range 1..15.
- EXC_VECTOR, 32'h800012a0, redirect target for every non-ERET exception.
- ERET_CODE, 32'h0000000e, excepttype value that selects cp0_epc_i.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- stallreq_i  in  NSTAGE  bit k = stage k requests a stall.
- mem_we_i  in  1  MEM-stage instruction is a store.
- excepttype_i  in  32  nonzero = exception committed in MEM.
- cp0_epc_i  in  32  EPC from CP0.
- stall_o  out  NSTAGE  stage hold mask.
- flush_o  out  1  flush all stage registers.
- new_pc_o  out  32  redirect target, valid when flush_o=1.
- mem_we_o  out  1  gated SRAM write strobe.
- store_busy_o  out  1  store sequencer not IDLE.

Behaviour:
- Reset (synchronous, rst=1 at posedge): sequencer -> IDLE, counter=0. While rst=1, all outputs are 0.
- Outputs are combinational from inputs and registered state. Sequencer state updates on posedge clk.
- Request mask: h = highest set index of stallreq_i. req_mask = bits 0..h set. Bit NSTAGE-1 is never driven.
- Priority, highest first:
  1. Exception: flush_o=1, stall_o=0, mem_we_o=0. new_pc_o = cp0_epc_i if excepttype_i==ERET_CODE, else EXC_VECTOR. Unknown nonzero codes also go to EXC_VECTOR.
  2. Any stallreq_i bit set: stall_o=req_mask, mem_we_o=0. Sequencer holds state and counter.
  3. Store sequencer output.
  4. Otherwise all outputs 0.
- new_pc_o = 0 whenever flush_o=0.
- Sequencer states:
  - IDLE, mem_we_i=1: stall_o = bits 0..MEM_STAGE. Load counter=STORE_WAIT-1. Next state WAIT, or COMMIT if STORE_WAIT=1.
  - WAIT: stall_o = bits 0..MEM_STAGE. Decrement counter. At 0, next state COMMIT.
  - COMMIT: mem_we_o=1, stall_o = bits 0..MEM_STAGE-1 (MEM advances). Next state IDLE.
  - Total store latency is STORE_WAIT+1 cycles; exactly one mem_we_o pulse per store.
- Exception in any sequencer state: next state IDLE, store aborted, no strobe.
- mem_we_i deasserted mid-sequence (flushed upstream): return to IDLE, no strobe.
- Back-to-back stores: COMMIT -> IDLE, then the next store restarts the full sequence.
- store_busy_o = (state != IDLE).

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined: adds outputs stall_cycles_o[31:0] and flush_count_o[31:0], both cleared by reset.
  - stall_cycles_o increments on each cycle with stall_o[0]=1.
  - flush_count_o increments on each cycle with flush_o=1.
  - Both saturate at 32'hffffffff.
- Undefined: ports and counters absent, no extra logic.

Decomposition:
- Shared package hazard_pkg:
  - sequencer state enum (IDLE/WAIT/COMMIT).
  - exception code constants: INT=1, SYS=8, INV=0xa, OVF=0xc, TRAP=0xd, ERET=0xe, TLBMISS=0xf.
  - default EXC_VECTOR.
- One sub-module, store_seq: FSM plus wait counter. Inputs mem_we_i, abort, hold. Outputs active, commit.
- Priority mux and mask generation stay in hazard_ctrl.

Test Plan:
- Reset, then idle inputs -> stall_o=000000, flush_o=0, new_pc_o=0, mem_we_o=0, store_busy_o=0.
- STORE_WAIT=2, mem_we_i=1 held -> stall_o=011111 for 2 cycles, then 001111 with mem_we_o=1 for 1 cycle, then IDLE.
- stallreq_i=000100 with stallreq_i=001000 the same cycle -> stall_o=001111. Release -> 000000.
- excepttype_i=0xe, cp0_epc_i=0x80001004 -> flush_o=1, new_pc_o=0x80001004, stall_o=0. excepttype_i=0x8 -> new_pc_o=0x800012a0.
- Exception during WAIT -> flush_o=1, no mem_we_o pulse ever, store_busy_o=0 next cycle.
- rst=1 during WAIT -> IDLE next cycle, no strobe. With HAZARD_PERF_CNT_EN: 3 stalled cycles -> stall_cycles_o=3.
